// File: rtl/mdu_hilo_unit_pkg.sv
// Shared definitions for the multiply/divide unit and the decoder that feeds it.
package mdu_hilo_unit_pkg;

   // MDUOP encodings produced by the decode stage.
   typedef enum logic [3:0] {
      MDU_NONE  = 4'b0000,
      MDU_MULT  = 4'b0001,
      MDU_MULTU = 4'b0010,
      MDU_DIV   = 4'b0011,
      MDU_DIVU  = 4'b0100,
      MDU_MTHI  = 4'b0101,
      MDU_MTLO  = 4'b0110,
      MDU_READ  = 4'b1111
   } mdu_op_e;

   // ReadHILO select encodings; any other value reads zero.
   localparam logic [1:0] RD_HI   = 2'b10;
   localparam logic [1:0] RD_LO   = 2'b01;
   localparam logic [1:0] RD_ZERO = 2'b00;

   // Default busy latencies the decoder sends on Time.
   localparam int unsigned MULT_TIME = 5;
   localparam int unsigned DIV_TIME  = 10;

   // IDLE means counter == 0, RUN means an op is in flight.
   typedef enum logic {StIdle, StRun} mdu_state_e;

   // True for the four ops that occupy the unit for a latency.
   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   // True for the two divide ops (divide-by-zero suppresses the commit).
   function automatic logic is_div(input logic [3:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_hilo_unit.sv
// E-stage multiply/divide unit owning HI/LO. Launches MULT/MULTU/DIV/DIVU with a
// programmable busy latency, applies MTHI/MTLO, and returns HI/LO for MFHI/MFLO.
module mdu_hilo_unit
   import mdu_hilo_unit_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Start,
   input  logic [3:0]        MDUOP,
   input  logic [CNT_W-1:0]  Time,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [1:0]        ReadHILO,
   output logic              Busy,
   output logic [DATA_W-1:0] HILOOut
);

   localparam int unsigned PW = 2 * DATA_W;

   mdu_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [PW-1:0]     pend_q, pend_d;
   logic              pend_dz_q, pend_dz_d;

   logic [PW-1:0]     a_sext, b_sext, a_zext, b_zext;
   logic [PW-1:0]     mul_s, mul_u;
   logic              a_neg, b_neg;
   logic [DATA_W-1:0] a_mag, b_mag, b_mag_safe, b_safe;
   logic [DATA_W-1:0] qu, ru, qs_mag, rs_mag, qs, rs;
   logic [PW-1:0]     result;
   logic              launch;

   // Products: the low 2*DATA_W bits of the extended operands give the exact result.
   assign a_sext = {{DATA_W{A[DATA_W-1]}}, A};
   assign b_sext = {{DATA_W{B[DATA_W-1]}}, B};
   assign a_zext = {{DATA_W{1'b0}}, A};
   assign b_zext = {{DATA_W{1'b0}}, B};
   assign mul_s  = a_sext * b_sext;
   assign mul_u  = a_zext * b_zext;

   // Divides: divisor forced to 1 on zero so no X propagates; that result is discarded.
   // Signed divide works on magnitudes, so 0x80000000 / -1 yields 0x80000000 naturally.
   assign a_neg      = A[DATA_W-1];
   assign b_neg      = B[DATA_W-1];
   assign a_mag      = a_neg ? ('0 - A) : A;
   assign b_mag      = b_neg ? ('0 - B) : B;
   assign b_mag_safe = (b_mag == '0) ? DATA_W'(1) : b_mag;
   assign b_safe     = (B == '0) ? DATA_W'(1) : B;
   assign qu         = A / b_safe;
   assign ru         = A % b_safe;
   assign qs_mag     = a_mag / b_mag_safe;
   assign rs_mag     = a_mag % b_mag_safe;
   assign qs         = (a_neg ^ b_neg) ? ('0 - qs_mag) : qs_mag;
   assign rs         = a_neg ? ('0 - rs_mag) : rs_mag;

   // Single result mux feeding the pending register, packed as {HI, LO}.
   always_comb begin
      result = '0;
      case (MDUOP)
         MDU_MULT:  result = mul_s;
         MDU_MULTU: result = mul_u;
         MDU_DIV:   result = {rs, qs};
         MDU_DIVU:  result = {ru, qu};
         default:   result = '0;
      endcase
   end

   assign launch = Start && is_muldiv(MDUOP);

   // Next-state: launch/move-to in IDLE, count down and commit in RUN.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_d    = pend_q;
      pend_dz_d = pend_dz_q;
      unique case (state_q)
         StIdle: begin
            if (launch) begin
               pend_d    = result;
               pend_dz_d = is_div(MDUOP) && (B == '0);
               cnt_d     = (Time == '0) ? CNT_W'(1) : Time;
               state_d   = StRun;
            end else if (MDUOP == MDU_MTHI) begin
               hi_d = A;
            end else if (MDUOP == MDU_MTLO) begin
               lo_d = A;
            end
         end
         StRun: begin
            // Start and MTHI/MTLO are ignored here; only the countdown advances.
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = StIdle;
               if (!pend_dz_q) begin
                  hi_d = pend_q[PW-1:DATA_W];
                  lo_d = pend_q[DATA_W-1:0];
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; reset discards any in-flight op.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_q    <= '0;
         pend_dz_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_q    <= pend_d;
         pend_dz_q <= pend_dz_d;
      end
   end

   assign Busy = (state_q == StRun);

   // Read port always shows committed HI/LO, never the pending result.
   always_comb begin
      HILOOut = '0;
      case (ReadHILO)
         RD_HI:   HILOOut = hi_q;
         RD_LO:   HILOOut = lo_q;
         default: HILOOut = '0;
      endcase
   end

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Scoreboard bench for mdu_hilo_unit: expected {HI,LO} pushed at launch, popped at completion.
module tb_mdu_hilo_unit;
   import mdu_hilo_unit_pkg::*;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              Start;
   logic [3:0]        MDUOP;
   logic [CNT_W-1:0]  Time;
   logic [DATA_W-1:0] A, B;
   logic [1:0]        ReadHILO;
   logic              Busy;
   logic [DATA_W-1:0] HILOOut;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] sb_q[$];
   logic [31:0] m_hi, m_lo;

   mdu_hilo_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .Start(Start), .MDUOP(MDUOP), .Time(Time),
      .A(A), .B(B), .ReadHILO(ReadHILO), .Busy(Busy), .HILOOut(HILOOut)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: {HI,LO} after completion, using the bench's own arithmetic.
   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] p;
      logic [31:0]        q, r;
      case (op)
         MDU_MULT: begin
            p = $signed(a) * $signed(b);
            return p;
         end
         MDU_MULTU: return {32'b0, a} * {32'b0, b};
         MDU_DIV: begin
            if (b == 32'd0) return {m_hi, m_lo};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
         end
         MDU_DIVU: begin
            if (b == 32'd0) return {m_hi, m_lo};
            return {a % b, a / b};
         end
         default: return {m_hi, m_lo};
      endcase
   endfunction

   // Advance to just after the next rising edge and return inputs to idle.
   task automatic tick();
      @(posedge clk);
      #1;
      Start = 1'b0;
      MDUOP = MDU_NONE;
   endtask

   task automatic get(input logic [1:0] sel, output logic [31:0] v);
      ReadHILO = sel;
      #1;
      v = HILOOut;
   endtask

   task automatic move_to(input logic [3:0] op, input logic [31:0] a);
      MDUOP = op;
      A     = a;
      tick();
      if (op == MDU_MTHI) m_hi = a;
      if (op == MDU_MTLO) m_lo = a;
   endtask

   // Launch an op and wait for Busy to fall; returns number of busy cycles seen.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t, output int busy_cnt);
      sb_q.push_back(model(op, a, b));
      Start = 1'b1;
      MDUOP = op;
      A     = a;
      B     = b;
      Time  = t;
      tick();
      busy_cnt = 0;
      while (Busy && busy_cnt < 40) begin
         busy_cnt++;
         tick();
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      reset = 1'b1;
      tick();
      n_cmp++;
      if (Busy !== 1'b0) begin
         n_bad++; $display("FAIL reset_busy: got %b want 0", Busy);
      end
      get(RD_HI, v);
      n_cmp++;
      if (v !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h want 0", v); end
      get(RD_LO, v);
      n_cmp++;
      if (v !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h want 0", v); end
      reset = 1'b0;
      m_hi = 32'h0;
      m_lo = 32'h0;
      tick();
   endtask

   task automatic test_mult();
      logic [63:0] exp;
      logic [31:0] v;
      int          bc;
      move_to(MDU_MTLO, 32'h0000_0055);
      sb_q.push_back(model(MDU_MULT, 32'hFFFF_FFFE, 32'h3));
      Start = 1'b1; MDUOP = MDU_MULT; A = 32'hFFFF_FFFE; B = 32'h3; Time = CNT_W'(MULT_TIME);
      tick();
      bc = 0;
      while (Busy && bc < 40) begin
         get(RD_LO, v);
         n_cmp++;
         if (v !== 32'h55) begin
            n_bad++; $display("FAIL mult_old_lo cycle %0d: got %h want 00000055", bc + 1, v);
         end
         bc++;
         tick();
      end
      n_cmp++;
      if (bc != MULT_TIME) begin n_bad++; $display("FAIL mult_busy: got %0d want 5", bc); end
      exp = sb_q.pop_front();
      get(RD_HI, v);
      n_cmp++;
      if (v !== exp[63:32]) begin n_bad++; $display("FAIL mult_hi: got %h want %h", v, exp[63:32]); end
      get(RD_LO, v);
      n_cmp++;
      if (v !== exp[31:0]) begin n_bad++; $display("FAIL mult_lo: got %h want %h", v, exp[31:0]); end
      {m_hi, m_lo} = exp;
   endtask

   task automatic test_multu_div();
      logic [63:0] exp;
      logic [31:0] vh, vl;
      int          bc;
      run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, CNT_W'(MULT_TIME), bc);
      exp = sb_q.pop_front();
      get(RD_HI, vh); get(RD_LO, vl);
      n_cmp++;
      if ({vh, vl} !== 64'hFFFF_FFFE_0000_0001 || bc != 5) begin
         n_bad++; $display("FAIL multu: got %h%h/%0d want fffffffe00000001/5", vh, vl, bc);
      end
      {m_hi, m_lo} = exp;
      run_op(MDU_DIV, 32'hFFFF_FFF9, 32'h2, CNT_W'(DIV_TIME), bc);
      exp = sb_q.pop_front();
      get(RD_HI, vh); get(RD_LO, vl);
      n_cmp++;
      if ({vh, vl} !== exp || bc != DIV_TIME) begin
         n_bad++; $display("FAIL div: got %h%h/%0d want %h/10", vh, vl, bc, exp);
      end
      {m_hi, m_lo} = exp;
   endtask

   task automatic test_div_edge();
      logic [63:0] exp;
      logic [31:0] vh, vl;
      int          bc;
      move_to(MDU_MTHI, 32'h11);
      move_to(MDU_MTLO, 32'h22);
      run_op(MDU_DIVU, 32'h7, 32'h0, CNT_W'(DIV_TIME), bc);
      exp = sb_q.pop_front();
      get(RD_HI, vh); get(RD_LO, vl);
      n_cmp++;
      if ({vh, vl} !== {32'h11, 32'h22} || bc != 10) begin
         n_bad++; $display("FAIL divu_zero: got %h %h/%0d want 11 22/10", vh, vl, bc);
      end
      {m_hi, m_lo} = exp;
      run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, CNT_W'(DIV_TIME), bc);
      exp = sb_q.pop_front();
      get(RD_HI, vh); get(RD_LO, vl);
      n_cmp++;
      if ({vh, vl} !== exp) begin
         n_bad++; $display("FAIL div_ovf: got %h%h want %h", vh, vl, exp);
      end
      {m_hi, m_lo} = exp;
   endtask

   task automatic test_ignore_busy();
      logic [63:0] exp;
      logic [31:0] vh, vl;
      int          bc;
      sb_q.push_back(model(MDU_MULT, 32'h3, 32'h4));
      Start = 1'b1; MDUOP = MDU_MULT; A = 32'h3; B = 32'h4; Time = CNT_W'(MULT_TIME);
      tick();
      bc = 0;
      while (Busy && bc < 40) begin
         if (bc == 0) begin
            MDUOP = MDU_MTLO; A = 32'h1234;
         end else if (bc == 1) begin
            Start = 1'b1; MDUOP = MDU_MULT; A = 32'd100; B = 32'd100; Time = 4'd9;
         end
         bc++;
         tick();
      end
      n_cmp++;
      if (bc != 5) begin n_bad++; $display("FAIL ignore_busy_len: got %0d want 5", bc); end
      exp = sb_q.pop_front();
      get(RD_HI, vh); get(RD_LO, vl);
      n_cmp++;
      if ({vh, vl} !== exp) begin
         n_bad++; $display("FAIL ignore_result: got %h%h want %h", vh, vl, exp);
      end
      {m_hi, m_lo} = exp;
   endtask

   task automatic test_reset_mid();
      logic [63:0] exp;
      logic [31:0] vh, vl;
      int          bc;
      sb_q.push_back(model(MDU_DIV, 32'd1000, 32'd7));
      Start = 1'b1; MDUOP = MDU_DIV; A = 32'd1000; B = 32'd7; Time = CNT_W'(DIV_TIME);
      tick();
      tick();
      tick();
      reset = 1'b1;
      #1;
      n_cmp++;
      if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid_busy: got %b want 0", Busy); end
      get(RD_HI, vh); get(RD_LO, vl);
      n_cmp++;
      if ({vh, vl} !== 64'h0) begin
         n_bad++; $display("FAIL reset_mid_hilo: got %h%h want 0", vh, vl);
      end
      reset = 1'b0;
      sb_q.delete();
      m_hi = 32'h0;
      m_lo = 32'h0;
      run_op(MDU_MULT, 32'h0001_0000, 32'hFFFF_0000, CNT_W'(MULT_TIME), bc);
      exp = sb_q.pop_front();
      get(RD_HI, vh); get(RD_LO, vl);
      n_cmp++;
      if ({vh, vl} !== exp || bc != 5) begin
         n_bad++; $display("FAIL reset_mid_relaunch: got %h%h/%0d want %h/5", vh, vl, bc, exp);
      end
      {m_hi, m_lo} = exp;
   endtask

   task automatic test_misc();
      logic [31:0] v;
      int          bc;
      logic [63:0] exp;
      // Start with a non-mult/div op: MTHI applies, no busy.
      Start = 1'b1; MDUOP = MDU_MTHI; A = 32'hCAFE_0001;
      tick();
      m_hi = 32'hCAFE_0001;
      get(RD_HI, v);
      n_cmp++;
      if (v !== m_hi || Busy !== 1'b0) begin
         n_bad++; $display("FAIL start_mthi: got %h busy %b want %h busy 0", v, Busy, m_hi);
      end
      get(RD_ZERO, v);
      n_cmp++;
      if (v !== 32'h0) begin n_bad++; $display("FAIL read_zero: got %h want 0", v); end
      run_op(MDU_MULTU, 32'd6, 32'd7, 4'd0, bc);
      exp = sb_q.pop_front();
      get(RD_LO, v);
      n_cmp++;
      if (bc != 1 || v !== exp[31:0]) begin
         n_bad++; $display("FAIL time0: got %0d/%h want 1/%h", bc, v, exp[31:0]);
      end
      {m_hi, m_lo} = exp;
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp;
      logic [31:0] vh, vl, a, b;
      logic [3:0]  op, t;
      int          bc;
      for (int i = 0; i < 8; i++) begin
         op = 4'($urandom_range(4, 1));
         t  = 4'($urandom_range(15, 1));
         a  = $urandom;
         b  = (i == 3) ? 32'h0 : $urandom;
         run_op(op, a, b, t, bc);
         exp = sb_q.pop_front();
         get(RD_HI, vh); get(RD_LO, vl);
         n_cmp++;
         if ({vh, vl} !== exp || bc != int'(t)) begin
            n_bad++;
            $display("FAIL b2b[%0d] op %0d a %h b %h: got %h%h/%0d want %h/%0d",
                     i, op, a, b, vh, vl, bc, exp, t);
         end
         {m_hi, m_lo} = exp;
      end
   endtask

   initial begin
      reset = 1'b1; Start = 1'b0; MDUOP = MDU_NONE; Time = '0;
      A = '0; B = '0; ReadHILO = RD_ZERO;
      m_hi = 32'h0; m_lo = 32'h0;
      #1;
      test_reset();
      test_mult();
      test_multu_div();
      test_div_edge();
      test_ignore_busy();
      test_reset_mid();
      test_misc();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
